// File: rtl/csr_trap_unit_pkg.sv
// Shared types and constants for the commit-side CSR / trap unit.
package csr_trap_unit_pkg;

   typedef enum logic [2:0] {
      NONE                   = 3'd0,
      INSTRUCTION_MISALIGNED = 3'd1,
      ILLEGAL_INSTRUCTION    = 3'd2,
      LOAD_MISALIGNED        = 3'd3,
      STORE_MISALIGNED       = 3'd4,
      ENVIRONMENT_CALL       = 3'd5
   } exception_t;

   typedef enum logic [1:0] {
      IRQ_NONE = 2'd0,
      IRQ_MSI  = 2'd1,
      IRQ_MTI  = 2'd2,
      IRQ_MEI  = 2'd3
   } interrupt_t;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_REDIRECT = 1'b1
   } trap_state_t;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;
   localparam logic [11:0] CSR_MIP      = 12'h344;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET = 12'hB02;
   localparam logic [11:0] CSR_MHARTID  = 12'hF14;

   localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
   localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
   localparam logic [3:0] CAUSE_MSI              = 4'd3;
   localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
   localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
   localparam logic [3:0] CAUSE_MTI              = 4'd7;
   localparam logic [3:0] CAUSE_ECALL_U          = 4'd8;
   localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;
   localparam logic [3:0] CAUSE_MEI              = 4'd11;

   localparam logic [1:0] PRIV_U = 2'd0;
   localparam logic [1:0] PRIV_M = 2'd3;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;
   localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_1888;

   // Synchronous exception cause; ECALL depends on the privilege it came from.
   function automatic logic [3:0] exc_code(input exception_t exc, input logic [1:0] priv);
      logic [3:0] code;
      code = CAUSE_ILLEGAL_INSTR;
      case (exc)
         INSTRUCTION_MISALIGNED: code = CAUSE_INSTR_MISALIGNED;
         ILLEGAL_INSTRUCTION:    code = CAUSE_ILLEGAL_INSTR;
         LOAD_MISALIGNED:        code = CAUSE_LOAD_MISALIGNED;
         STORE_MISALIGNED:       code = CAUSE_STORE_MISALIGNED;
         ENVIRONMENT_CALL:       code = (priv == PRIV_M) ? CAUSE_ECALL_M : CAUSE_ECALL_U;
         default:                code = CAUSE_ILLEGAL_INSTR;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/csr_trap_unit_if.sv
// Commit, redirect and decode-read signals between the pipeline and the trap unit.
interface csr_trap_unit_if;
   import csr_trap_unit_pkg::*;

   logic        commit_valid;
   logic        commit_ready;
   logic [63:0] commit_pc;
   exception_t  commit_exception;
   logic        commit_mret;
   logic        commit_csr_we;
   logic [11:0] commit_csr_addr;
   logic [63:0] commit_csr_wdata;
   logic [11:0] csr_raddr;
   logic [63:0] csr_rdata;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        redirect_ready;

   modport master (
      output commit_valid, commit_pc, commit_exception, commit_mret,
      output commit_csr_we, commit_csr_addr, commit_csr_wdata, csr_raddr,
      output redirect_ready,
      input  commit_ready, csr_rdata, redirect_valid, redirect_pc
   );

   modport slave (
      input  commit_valid, commit_pc, commit_exception, commit_mret,
      input  commit_csr_we, commit_csr_addr, commit_csr_wdata, csr_raddr,
      input  redirect_ready,
      output commit_ready, csr_rdata, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/csr_trap_unit_csr_regfile.sv
// Machine-mode CSR storage and combinational read mux.
module csr_trap_unit_csr_regfile
   import csr_trap_unit_pkg::*;
#(
   parameter logic [63:0] MTVEC_RESET = 64'h0,
   parameter logic [63:0] HART_ID     = 64'h0
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_csr_we,
   input  logic [11:0] i_csr_addr,
   input  logic [63:0] i_csr_wdata,
   input  logic        i_trap,
   input  logic [63:0] i_trap_cause,
   input  logic [63:0] i_trap_pc,
   input  logic [63:0] i_trap_tval,
   input  logic        i_mret,
   input  logic        i_retire,
   input  logic [1:0]  i_priv,
   input  logic        i_trint,
   input  logic        i_swint,
   input  logic        i_exint,
   input  logic [11:0] i_raddr,
   output logic [63:0] o_rdata,
   output logic        o_mstatus_mie,
   output logic [1:0]  o_mstatus_mpp,
   output logic        o_mie_meie,
   output logic        o_mie_msie,
   output logic        o_mie_mtie,
   output logic [63:0] o_mtvec,
   output logic [63:0] o_mepc
);

   logic [63:0] r_mstatus, r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
   logic [63:0] r_mcycle, r_minstret;
   logic [63:0] w_mip;

   assign w_mip = {52'd0, i_exint, 3'd0, i_trint, 3'd0, i_swint, 3'd0};

   // Register updates: trap/mret side effects first, then the (already gated) CSR write.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_mstatus  <= '0;
         r_mie      <= '0;
         r_mtvec    <= MTVEC_RESET;
         r_mscratch <= '0;
         r_mepc     <= '0;
         r_mcause   <= '0;
         r_mtval    <= '0;
         r_mcycle   <= '0;
         r_minstret <= '0;
      end else begin
         r_mcycle <= r_mcycle + 64'd1;
         if (i_retire) r_minstret <= r_minstret + 64'd1;
         if (i_trap) begin
            r_mepc                                  <= i_trap_pc;
            r_mcause                                <= i_trap_cause;
            r_mtval                                 <= i_trap_tval;
            r_mstatus[MSTATUS_MPIE]                 <= r_mstatus[MSTATUS_MIE];
            r_mstatus[MSTATUS_MIE]                  <= 1'b0;
            r_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= i_priv;
         end else if (i_mret) begin
            r_mstatus[MSTATUS_MIE]                  <= r_mstatus[MSTATUS_MPIE];
            r_mstatus[MSTATUS_MPIE]                 <= 1'b1;
            r_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= PRIV_U;
         end
         if (i_csr_we) begin
            case (i_csr_addr)
               CSR_MSTATUS:  r_mstatus  <= i_csr_wdata & MSTATUS_WMASK;
               CSR_MIE:      r_mie      <= i_csr_wdata;
               CSR_MTVEC:    r_mtvec    <= i_csr_wdata;
               CSR_MSCRATCH: r_mscratch <= i_csr_wdata;
               CSR_MEPC:     r_mepc     <= i_csr_wdata;
               CSR_MCAUSE:   r_mcause   <= i_csr_wdata;
               CSR_MTVAL:    r_mtval    <= i_csr_wdata;
               CSR_MCYCLE:   r_mcycle   <= i_csr_wdata;
               CSR_MINSTRET: r_minstret <= i_csr_wdata;
               default: ;
            endcase
         end
      end
   end

   // Decode-stage read port; unmapped addresses read as zero.
   always_comb begin
      o_rdata = '0;
      case (i_raddr)
         CSR_MSTATUS:  o_rdata = r_mstatus;
         CSR_MIE:      o_rdata = r_mie;
         CSR_MTVEC:    o_rdata = r_mtvec;
         CSR_MSCRATCH: o_rdata = r_mscratch;
         CSR_MEPC:     o_rdata = r_mepc;
         CSR_MCAUSE:   o_rdata = r_mcause;
         CSR_MTVAL:    o_rdata = r_mtval;
         CSR_MIP:      o_rdata = w_mip;
         CSR_MCYCLE:   o_rdata = r_mcycle;
         CSR_MINSTRET: o_rdata = r_minstret;
         CSR_MHARTID:  o_rdata = HART_ID;
         default:      o_rdata = '0;
      endcase
   end

   assign o_mstatus_mie = r_mstatus[MSTATUS_MIE];
   assign o_mstatus_mpp = r_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
   assign o_mie_meie    = r_mie[11];
   assign o_mie_msie    = r_mie[3];
   assign o_mie_mtie    = r_mie[7];
   assign o_mtvec       = r_mtvec;
   assign o_mepc        = r_mepc;

endmodule

// File: rtl/csr_trap_unit.sv
// Commit-side trap / mret sequencer: picks the winning event of an accepted
// commit, updates privilege, and holds a fetch redirect until it is taken.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | accepting commits; normal commits retire here
// ST_REDIRECT | redirect_valid high, redirect_pc held, commits ignored
module csr_trap_unit
   import csr_trap_unit_pkg::*;
#(
   parameter logic [63:0] MTVEC_RESET = 64'h0,
   parameter logic [63:0] HART_ID     = 64'h0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   csr_trap_unit_if.slave   bus,
   input  logic             i_trint,
   input  logic             i_swint,
   input  logic             i_exint,
   output logic [1:0]       o_priv_mode
);

   trap_state_t r_state, w_state_next;
   logic [1:0]  r_priv;
   logic [63:0] r_redirect_pc;

   logic        w_mstatus_mie, w_mie_meie, w_mie_msie, w_mie_mtie;
   logic [1:0]  w_mstatus_mpp;
   logic [63:0] w_mtvec, w_mepc;
   interrupt_t  w_irq_sel;
   logic        w_accept, w_irq_en, w_is_irq, w_is_exc, w_trap, w_is_mret, w_retire, w_csr_we;
   logic [3:0]  w_code;
   logic [63:0] w_cause, w_tval, w_base, w_trap_target;

   assign w_accept  = bus.commit_valid && (r_state == ST_IDLE);
   assign w_irq_en  = (r_priv < PRIV_M) || w_mstatus_mie;
   assign w_is_irq  = w_accept && w_irq_en && (w_irq_sel != IRQ_NONE);
   assign w_is_exc  = w_accept && !w_is_irq && (bus.commit_exception != NONE);
   assign w_trap    = w_is_irq || w_is_exc;
   assign w_is_mret = w_accept && !w_trap && bus.commit_mret;
   assign w_retire  = w_accept && !w_trap;
   assign w_csr_we  = w_retire && !bus.commit_mret && bus.commit_csr_we;

   // Pending-and-enabled interrupt with MEI > MSI > MTI priority.
   always_comb begin
      w_irq_sel = IRQ_NONE;
      if (w_mie_meie && i_exint)      w_irq_sel = IRQ_MEI;
      else if (w_mie_msie && i_swint) w_irq_sel = IRQ_MSI;
      else if (w_mie_mtie && i_trint) w_irq_sel = IRQ_MTI;
   end

   // Cause code of the winning trap.
   always_comb begin
      w_code = exc_code(bus.commit_exception, r_priv);
      if (w_is_irq) begin
         case (w_irq_sel)
            IRQ_MEI: w_code = CAUSE_MEI;
            IRQ_MSI: w_code = CAUSE_MSI;
            IRQ_MTI: w_code = CAUSE_MTI;
            default: w_code = CAUSE_MEI;
         endcase
      end
   end

   assign w_cause = {w_is_irq, 59'd0, w_code};
   assign w_tval  = (!w_is_irq && bus.commit_exception == INSTRUCTION_MISALIGNED) ? bus.commit_pc : 64'd0;
   assign w_base  = {w_mtvec[63:2], 2'b00};
   // Vectored mode only offsets interrupts; exceptions always land on the base.
   assign w_trap_target = (w_is_irq && w_mtvec[1:0] == 2'b01) ? w_base + {58'd0, w_code, 2'b00} : w_base;

   csr_trap_unit_csr_regfile #(
      .MTVEC_RESET (MTVEC_RESET),
      .HART_ID     (HART_ID)
   ) u_regfile (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_csr_we      (w_csr_we),
      .i_csr_addr    (bus.commit_csr_addr),
      .i_csr_wdata   (bus.commit_csr_wdata),
      .i_trap        (w_trap),
      .i_trap_cause  (w_cause),
      .i_trap_pc     (bus.commit_pc),
      .i_trap_tval   (w_tval),
      .i_mret        (w_is_mret),
      .i_retire      (w_retire),
      .i_priv        (r_priv),
      .i_trint       (i_trint),
      .i_swint       (i_swint),
      .i_exint       (i_exint),
      .i_raddr       (bus.csr_raddr),
      .o_rdata       (bus.csr_rdata),
      .o_mstatus_mie (w_mstatus_mie),
      .o_mstatus_mpp (w_mstatus_mpp),
      .o_mie_meie    (w_mie_meie),
      .o_mie_msie    (w_mie_msie),
      .o_mie_mtie    (w_mie_mtie),
      .o_mtvec       (w_mtvec),
      .o_mepc        (w_mepc)
   );

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (!i_reset) r_state <= ST_IDLE;
      else          r_state <= w_state_next;
   end

   // FSM next state.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:     if (w_trap || w_is_mret) w_state_next = ST_REDIRECT;
         ST_REDIRECT: if (bus.redirect_ready)  w_state_next = ST_IDLE;
         default:     w_state_next = ST_IDLE;
      endcase
   end

   // Privilege and redirect target, latched on the accepting edge.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_priv        <= PRIV_M;
         r_redirect_pc <= '0;
      end else if (w_trap) begin
         r_priv        <= PRIV_M;
         r_redirect_pc <= w_trap_target;
      end else if (w_is_mret) begin
         r_priv        <= w_mstatus_mpp;
         r_redirect_pc <= w_mepc;
      end
   end

   assign bus.commit_ready   = (r_state == ST_IDLE);
   assign bus.redirect_valid = (r_state == ST_REDIRECT);
   assign bus.redirect_pc    = r_redirect_pc;
   assign o_priv_mode        = r_priv;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit.
module tb_csr_trap_unit;
   import csr_trap_unit_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       trint, swint, exint;
   logic [1:0] priv_mode;
   int         checks = 0;
   int         errors = 0;

   csr_trap_unit_if u_if ();

   csr_trap_unit #(
      .MTVEC_RESET (64'h100),
      .HART_ID     (64'h5)
   ) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .bus         (u_if),
      .i_trint     (trint),
      .i_swint     (swint),
      .i_exint     (exint),
      .o_priv_mode (priv_mode)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_commit();
      u_if.commit_valid     = 1'b0;
      u_if.commit_pc        = '0;
      u_if.commit_exception = NONE;
      u_if.commit_mret      = 1'b0;
      u_if.commit_csr_we    = 1'b0;
      u_if.commit_csr_addr  = '0;
      u_if.commit_csr_wdata = '0;
   endtask

   task automatic drive_commit(input logic [63:0] pc, input exception_t exc, input logic mret,
                               input logic we, input logic [11:0] addr, input logic [63:0] wdata);
      u_if.commit_valid     = 1'b1;
      u_if.commit_pc        = pc;
      u_if.commit_exception = exc;
      u_if.commit_mret      = mret;
      u_if.commit_csr_we    = we;
      u_if.commit_csr_addr  = addr;
      u_if.commit_csr_wdata = wdata;
   endtask

   task automatic csr_write(input logic [11:0] addr, input logic [63:0] wdata);
      drive_commit(64'h0, NONE, 1'b0, 1'b1, addr, wdata);
      step();
      clear_commit();
   endtask

   task automatic rd(input logic [11:0] addr);
      u_if.csr_raddr = addr;
      #1;
   endtask

   task automatic release_redirect();
      u_if.redirect_ready = 1'b1;
      step();
      u_if.redirect_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      step();
      step();
      rd(CSR_MTVEC);
      checks++; if (u_if.csr_rdata !== 64'h100) begin errors++; $display("FAIL reset_mtvec: got %h want %h", u_if.csr_rdata, 64'h100); end
      checks++; if (priv_mode !== 2'd3) begin errors++; $display("FAIL reset_priv: got %0d want 3", priv_mode); end
      checks++; if (u_if.redirect_valid !== 1'b0 || u_if.commit_ready !== 1'b1) begin errors++; $display("FAIL reset_handshake: redirect_valid %b commit_ready %b want 0 1", u_if.redirect_valid, u_if.commit_ready); end
      rd(CSR_MCYCLE);
      checks++; if (u_if.csr_rdata !== 64'd0) begin errors++; $display("FAIL reset_mcycle: got %0d want 0", u_if.csr_rdata); end
      reset = 1'b1;
      step();
      rd(CSR_MCYCLE);
      checks++; if (u_if.csr_rdata !== 64'd1) begin errors++; $display("FAIL mcycle_inc1: got %0d want 1", u_if.csr_rdata); end
      step();
      rd(CSR_MCYCLE);
      checks++; if (u_if.csr_rdata !== 64'd2) begin errors++; $display("FAIL mcycle_inc2: got %0d want 2", u_if.csr_rdata); end
      rd(CSR_MHARTID);
      checks++; if (u_if.csr_rdata !== 64'd5) begin errors++; $display("FAIL mhartid: got %0d want 5", u_if.csr_rdata); end
   endtask

   task automatic test_csr_write();
      drive_commit(64'h10, NONE, 1'b0, 1'b1, CSR_MSCRATCH, 64'h55);
      rd(CSR_MSCRATCH);
      checks++; if (u_if.csr_rdata !== 64'h0) begin errors++; $display("FAIL same_cycle_read: got %h want 0", u_if.csr_rdata); end
      step();
      clear_commit();
      rd(CSR_MSCRATCH);
      checks++; if (u_if.csr_rdata !== 64'h55) begin errors++; $display("FAIL mscratch_write: got %h want 55", u_if.csr_rdata); end
      drive_commit(64'h20, LOAD_MISALIGNED, 1'b0, 1'b1, CSR_MSCRATCH, 64'h66);
      step();
      clear_commit();
      rd(CSR_MSCRATCH);
      checks++; if (u_if.csr_rdata !== 64'h55) begin errors++; $display("FAIL write_suppressed: got %h want 55", u_if.csr_rdata); end
      rd(CSR_MCAUSE);
      checks++; if (u_if.csr_rdata !== 64'd4) begin errors++; $display("FAIL load_misaligned_cause: got %h want 4", u_if.csr_rdata); end
      rd(CSR_MINSTRET);
      checks++; if (u_if.csr_rdata !== 64'd1) begin errors++; $display("FAIL exc_no_retire: got %0d want 1", u_if.csr_rdata); end
      checks++; if (u_if.redirect_valid !== 1'b1 || u_if.redirect_pc !== 64'h100) begin errors++; $display("FAIL exc_redirect: valid %b pc %h want 1 100", u_if.redirect_valid, u_if.redirect_pc); end
      release_redirect();
      csr_write(12'h7C0, 64'h12);
      rd(12'h7C0);
      checks++; if (u_if.csr_rdata !== 64'h0) begin errors++; $display("FAIL unknown_csr: got %h want 0", u_if.csr_rdata); end
      swint = 1'b1;
      rd(CSR_MIP);
      checks++; if (u_if.csr_rdata !== 64'h8) begin errors++; $display("FAIL mip_msip: got %h want 8", u_if.csr_rdata); end
      swint = 1'b0;
   endtask

   task automatic test_ecall();
      csr_write(CSR_MTVEC, 64'h8000_0000);
      csr_write(CSR_MSTATUS, 64'h8);
      drive_commit(64'h1000, ENVIRONMENT_CALL, 1'b0, 1'b0, 12'h0, 64'h0);
      step();
      clear_commit();
      checks++; if (u_if.redirect_valid !== 1'b1 || u_if.redirect_pc !== 64'h8000_0000) begin errors++; $display("FAIL ecall_redirect: valid %b pc %h want 1 80000000", u_if.redirect_valid, u_if.redirect_pc); end
      rd(CSR_MEPC);
      checks++; if (u_if.csr_rdata !== 64'h1000) begin errors++; $display("FAIL ecall_mepc: got %h want 1000", u_if.csr_rdata); end
      rd(CSR_MCAUSE);
      checks++; if (u_if.csr_rdata !== 64'd11) begin errors++; $display("FAIL ecall_mcause: got %h want b", u_if.csr_rdata); end
      rd(CSR_MSTATUS);
      checks++; if (u_if.csr_rdata !== 64'h1880) begin errors++; $display("FAIL ecall_mstatus: got %h want 1880", u_if.csr_rdata); end
      rd(CSR_MINSTRET);
      checks++; if (u_if.csr_rdata !== 64'd4) begin errors++; $display("FAIL ecall_minstret: got %0d want 4", u_if.csr_rdata); end
   endtask

   task automatic test_backpressure();
      u_if.redirect_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_commit(64'h1100, NONE, 1'b0, 1'b1, CSR_MSCRATCH, 64'hAA);
         step();
         checks++; if (u_if.redirect_valid !== 1'b1 || u_if.redirect_pc !== 64'h8000_0000 || u_if.commit_ready !== 1'b0) begin errors++; $display("FAIL hold_cycle%0d: valid %b pc %h ready %b want 1 80000000 0", i, u_if.redirect_valid, u_if.redirect_pc, u_if.commit_ready); end
      end
      clear_commit();
      rd(CSR_MINSTRET);
      checks++; if (u_if.csr_rdata !== 64'd4) begin errors++; $display("FAIL hold_minstret: got %0d want 4", u_if.csr_rdata); end
      rd(CSR_MSCRATCH);
      checks++; if (u_if.csr_rdata !== 64'h55) begin errors++; $display("FAIL hold_mscratch: got %h want 55", u_if.csr_rdata); end
      release_redirect();
      checks++; if (u_if.redirect_valid !== 1'b0 || u_if.commit_ready !== 1'b1) begin errors++; $display("FAIL release_idle: valid %b ready %b want 0 1", u_if.redirect_valid, u_if.commit_ready); end
   endtask

   task automatic test_mret();
      csr_write(CSR_MEPC, 64'h2004);
      csr_write(CSR_MSTATUS, 64'h80);
      drive_commit(64'h3000, NONE, 1'b1, 1'b0, 12'h0, 64'h0);
      step();
      clear_commit();
      checks++; if (u_if.redirect_valid !== 1'b1 || u_if.redirect_pc !== 64'h2004) begin errors++; $display("FAIL mret_redirect: valid %b pc %h want 1 2004", u_if.redirect_valid, u_if.redirect_pc); end
      checks++; if (priv_mode !== 2'd0) begin errors++; $display("FAIL mret_priv: got %0d want 0", priv_mode); end
      rd(CSR_MSTATUS);
      checks++; if (u_if.csr_rdata !== 64'h88) begin errors++; $display("FAIL mret_mstatus: got %h want 88", u_if.csr_rdata); end
      release_redirect();
   endtask

   task automatic test_vectored_irq();
      csr_write(CSR_MTVEC, 64'h8000_0001);
      csr_write(CSR_MIE, 64'h888);
      csr_write(CSR_MSTATUS, 64'h8);
      exint = 1'b1;
      trint = 1'b1;
      drive_commit(64'h4000, ILLEGAL_INSTRUCTION, 1'b0, 1'b0, 12'h0, 64'h0);
      step();
      clear_commit();
      rd(CSR_MCAUSE);
      checks++; if (u_if.csr_rdata !== 64'h8000_0000_0000_000B) begin errors++; $display("FAIL irq_mcause: got %h want 800000000000000b", u_if.csr_rdata); end
      checks++; if (u_if.redirect_valid !== 1'b1 || u_if.redirect_pc !== 64'h8000_002C) begin errors++; $display("FAIL irq_vector: valid %b pc %h want 1 8000002c", u_if.redirect_valid, u_if.redirect_pc); end
      rd(CSR_MEPC);
      checks++; if (u_if.csr_rdata !== 64'h4000) begin errors++; $display("FAIL irq_mepc: got %h want 4000", u_if.csr_rdata); end
      rd(CSR_MSTATUS);
      checks++; if (u_if.csr_rdata !== 64'h80 || priv_mode !== 2'd3) begin errors++; $display("FAIL irq_mstatus_priv: mstatus %h priv %0d want 80 3", u_if.csr_rdata, priv_mode); end
      exint = 1'b0;
      release_redirect();
      drive_commit(64'h4004, NONE, 1'b0, 1'b0, 12'h0, 64'h0);
      step();
      clear_commit();
      checks++; if (u_if.redirect_valid !== 1'b0) begin errors++; $display("FAIL irq_masked_in_m: redirect_valid %b want 0", u_if.redirect_valid); end
      trint = 1'b0;
   endtask

   task automatic test_reset_mid_redirect();
      drive_commit(64'h5000, ENVIRONMENT_CALL, 1'b0, 1'b0, 12'h0, 64'h0);
      step();
      clear_commit();
      checks++; if (u_if.redirect_valid !== 1'b1 || u_if.redirect_pc !== 64'h8000_0000) begin errors++; $display("FAIL pre_reset_redirect: valid %b pc %h want 1 80000000", u_if.redirect_valid, u_if.redirect_pc); end
      reset = 1'b0;
      step();
      checks++; if (u_if.redirect_valid !== 1'b0 || u_if.redirect_pc !== 64'h0 || u_if.commit_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_redirect: valid %b pc %h ready %b want 0 0 1", u_if.redirect_valid, u_if.redirect_pc, u_if.commit_ready); end
      rd(CSR_MTVEC);
      checks++; if (u_if.csr_rdata !== 64'h100) begin errors++; $display("FAIL reset_mid_mtvec: got %h want 100", u_if.csr_rdata); end
      rd(CSR_MEPC);
      checks++; if (u_if.csr_rdata !== 64'h0) begin errors++; $display("FAIL reset_mid_mepc: got %h want 0", u_if.csr_rdata); end
      reset = 1'b1;
      step();
   endtask

   initial begin
      reset = 1'b0;
      trint = 1'b0;
      swint = 1'b0;
      exint = 1'b0;
      u_if.redirect_ready = 1'b0;
      u_if.csr_raddr      = '0;
      clear_commit();
      test_reset();
      test_csr_write();
      test_ecall();
      test_backpressure();
      test_mret();
      test_vectored_irq();
      test_reset_mid_redirect();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
